// File: rtl/digit_window_scroller.sv
// digit_window_scroller: turns up/down buttons (with hold-to-repeat) and an
// auto-sweep mode into clamped single-cycle shift pulses for the digit drawer,
// while tracking the drawer's window position locally.
module digit_window_scroller #(
   parameter int NUM_POSITIONS = 12,
   parameter int DEFAULT_POS   = 9,
   parameter int HOLD_CYCLES   = 4,
   parameter int REPEAT_CYCLES = 2,
   parameter int DWELL_CYCLES  = 3,
   parameter int PW            = $clog2(NUM_POSITIONS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ena,
   input  logic          btn_up,
   input  logic          btn_down,
   input  logic          auto_en,
   output logic          shift_up,
   output logic          shift_down,
   output logic [PW-1:0] pos,
   output logic          at_top,
   output logic          at_bottom
);

   localparam int CMAX = (HOLD_CYCLES > REPEAT_CYCLES)
                         ? ((HOLD_CYCLES > DWELL_CYCLES) ? HOLD_CYCLES : DWELL_CYCLES)
                         : ((REPEAT_CYCLES > DWELL_CYCLES) ? REPEAT_CYCLES : DWELL_CYCLES);
   localparam int CW = $clog2(CMAX) + 1;

   localparam logic [PW-1:0] TOP_POS    = PW'(NUM_POSITIONS - 1);
   localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] REP_LAST   = CW'(REPEAT_CYCLES - 1);
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE, HOLD_UP, REP_UP, HOLD_DOWN, REP_DOWN, AUTO
   } state_t;

   state_t        state, state_nxt, rel_state;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          dir_up, dir_up_nxt;
   logic          req_up, req_dn, req_up_q, req_dn_q;
   logic          edge_up, edge_dn;
   logic          step_up, step_dn, up_nxt, dn_nxt;
   logic [PW-1:0] pos_nxt;

   assign at_top    = (pos == TOP_POS);
   assign at_bottom = (pos == '0);

   // where a released press goes: back to sweeping if auto mode is on
   assign rel_state = auto_en ? AUTO : IDLE;

   // resolve the buttons into exclusive requests and find their rising edges
   always_comb begin
      req_up  = btn_up & ~btn_down;
      req_dn  = btn_down & ~btn_up;
      edge_up = req_up & ~req_up_q;
      edge_dn = req_dn & ~req_dn_q;
   end

   // next-state logic: a new press always wins, then per-state timing slots
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      dir_up_nxt = dir_up;
      step_up    = 1'b0;
      step_dn    = 1'b0;
      if (edge_up) begin
         state_nxt = HOLD_UP;
         cnt_nxt   = '0;
         step_up   = 1'b1;
      end else if (edge_dn) begin
         state_nxt = HOLD_DOWN;
         cnt_nxt   = '0;
         step_dn   = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (auto_en && !req_up && !req_dn) begin
                  state_nxt = AUTO;
                  cnt_nxt   = '0;
               end
            end
            HOLD_UP, REP_UP: begin
               if (!req_up) begin
                  state_nxt = rel_state;
                  cnt_nxt   = '0;
               end else if (cnt == ((state == HOLD_UP) ? HOLD_LAST : REP_LAST)) begin
                  state_nxt = REP_UP;
                  cnt_nxt   = '0;
                  step_up   = 1'b1;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            HOLD_DOWN, REP_DOWN: begin
               if (!req_dn) begin
                  state_nxt = rel_state;
                  cnt_nxt   = '0;
               end else if (cnt == ((state == HOLD_DOWN) ? HOLD_LAST : REP_LAST)) begin
                  state_nxt = REP_DOWN;
                  cnt_nxt   = '0;
                  step_dn   = 1'b1;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            AUTO: begin
               if (!auto_en) begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
               end else if (cnt == DWELL_LAST) begin
                  cnt_nxt = '0;
                  // at a limit the slot is spent turning around, not stepping
                  if (dir_up) begin
                     if (at_top) dir_up_nxt = 1'b0;
                     else        step_up    = 1'b1;
                  end else begin
                     if (at_bottom) dir_up_nxt = 1'b1;
                     else           step_dn    = 1'b1;
                  end
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // clamp: a step at a limit is dropped, position moves with the pulse
   always_comb begin
      up_nxt  = step_up & ~at_top;
      dn_nxt  = step_dn & ~at_bottom;
      pos_nxt = pos;
      if (up_nxt)      pos_nxt = pos + PW'(1);
      else if (dn_nxt) pos_nxt = pos - PW'(1);
   end

   // state register; ena freezes everything except forcing pulses low.
   // Edge history resets to "pressed" so a button held through reset must be
   // released and pressed again before it scrolls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         dir_up     <= 1'b1;
         pos        <= PW'(DEFAULT_POS);
         shift_up   <= 1'b0;
         shift_down <= 1'b0;
         req_up_q   <= 1'b1;
         req_dn_q   <= 1'b1;
      end else if (ena) begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         dir_up     <= dir_up_nxt;
         pos        <= pos_nxt;
         shift_up   <= up_nxt;
         shift_down <= dn_nxt;
         req_up_q   <= req_up;
         req_dn_q   <= req_dn;
      end else begin
         shift_up   <= 1'b0;
         shift_down <= 1'b0;
      end
   end

endmodule

// File: tb/tb_digit_window_scroller.sv
// tb_digit_window_scroller: directed scenarios plus a random soak, all
// compared every cycle against a behavioural press/sweep model.
module tb_digit_window_scroller;

   localparam int NP = 12;
   localparam int DP = 9;
   localparam int HC = 4;
   localparam int RC = 2;
   localparam int DC = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ena = 1'b1;
   logic       btn_up = 1'b0;
   logic       btn_down = 1'b0;
   logic       auto_en = 1'b0;
   logic       shift_up, shift_down, at_top, at_bottom;
   logic [3:0] pos;

   int checks = 0;
   int errors = 0;
   int n_up   = 0;
   int n_dn   = 0;

   // reference model: position, sweep direction, active press and its timing
   int m_pos, m_dir, m_press, m_slots, m_since, m_dwell;
   bit m_auto, m_pu, m_pd, m_pru, m_prd;

   always #5 clk = ~clk;

   digit_window_scroller #(
      .NUM_POSITIONS(NP), .DEFAULT_POS(DP), .HOLD_CYCLES(HC),
      .REPEAT_CYCLES(RC), .DWELL_CYCLES(DC)
   ) dut (
      .clk(clk), .rst(rst), .ena(ena), .btn_up(btn_up), .btn_down(btn_down),
      .auto_en(auto_en), .shift_up(shift_up), .shift_down(shift_down),
      .pos(pos), .at_top(at_top), .at_bottom(at_bottom)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic mreset();
      m_pos = DP; m_dir = 1; m_press = 0; m_slots = 0; m_since = 0;
      m_dwell = 0; m_auto = 0; m_pu = 0; m_pd = 0; m_pru = 1; m_prd = 1;
   endtask

   task automatic mstep();
      bit ru, rd, eu, ed;
      int want, gap;
      ru = btn_up && !btn_down;
      rd = btn_down && !btn_up;
      if (!ena) begin
         m_pu = 0; m_pd = 0;
         return;
      end
      want = 0;
      eu = ru && !m_pru;
      ed = rd && !m_prd;
      m_pru = ru; m_prd = rd;
      if (eu || ed) begin
         m_press = eu ? 1 : -1;
         m_slots = 1; m_since = 0; m_auto = 0;
         want = m_press;
      end else if (m_press != 0) begin
         if ((m_press == 1 && !ru) || (m_press == -1 && !rd)) begin
            m_press = 0; m_auto = auto_en; m_dwell = 0;
         end else begin
            m_since++;
            gap = (m_slots == 1) ? HC : RC;
            if (m_since == gap) begin
               want = m_press; m_slots++; m_since = 0;
            end
         end
      end else if (m_auto) begin
         if (!auto_en) m_auto = 0;
         else begin
            m_dwell++;
            if (m_dwell == DC) begin
               m_dwell = 0;
               if ((m_dir == 1 && m_pos == NP-1) || (m_dir == -1 && m_pos == 0)) m_dir = -m_dir;
               else want = m_dir;
            end
         end
      end else if (auto_en && !ru && !rd) begin
         m_auto = 1; m_dwell = 0;
      end
      m_pu = (want == 1) && (m_pos < NP-1);
      m_pd = (want == -1) && (m_pos > 0);
      if (m_pu) m_pos++;
      if (m_pd) m_pos--;
   endtask

   // one clock: advance model, then compare all outputs after the edge
   task automatic cyc();
      @(posedge clk);
      if (!rst) mreset();
      else mstep();
      #1;
      chk("m_up", shift_up, m_pu);
      chk("m_dn", shift_down, m_pd);
      chk("m_pos", pos, m_pos);
      chk("m_top", at_top, m_pos == NP-1);
      chk("m_bot", at_bottom, m_pos == 0);
      if (shift_up) n_up++;
      if (shift_down) n_dn++;
   endtask

   task automatic run(input int n);
      repeat (n) cyc();
   endtask

   initial begin
      mreset();
      // reset values
      run(10);
      chk("rst_pos", pos, 9);
      chk("rst_up", shift_up, 0);
      chk("rst_dn", shift_down, 0);
      chk("rst_top", at_top, 0);
      chk("rst_bot", at_bottom, 0);
      rst = 1'b1;
      run(2);

      // single tap up
      n_up = 0;
      btn_up = 1'b1; cyc(); btn_up = 1'b0;
      chk("tap_up", shift_up, 1);
      chk("tap_pos", pos, 10);
      run(3);
      chk("tap_cnt", n_up, 1);
      btn_down = 1'b1; cyc(); btn_down = 1'b0;
      run(2);
      chk("back9", pos, 9);

      // hold up into the top clamp
      n_up = 0;
      btn_up = 1'b1; run(20); btn_up = 1'b0; run(2);
      chk("hold_cnt", n_up, 2);
      chk("hold_pos", pos, 11);
      chk("hold_top", at_top, 1);

      // two taps down back to 9
      repeat (2) begin
         btn_down = 1'b1; cyc(); btn_down = 1'b0; cyc();
      end

      // both buttons: no request
      n_up = 0; n_dn = 0;
      btn_up = 1'b1; btn_down = 1'b1; run(10);
      chk("both_cnt", n_up + n_dn, 0);
      chk("both_pos", pos, 9);

      // release up leaving down alone: new down press, repeat timing
      btn_up = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         cyc();
         chk("dn_pulse", shift_down, (i == 1 || i == 5 || i == 7 || i == 9));
         if (i == 9) chk("dn_pos5", pos, 5);
      end
      run(12);
      chk("dn_pos0", pos, 0);
      chk("dn_bot", at_bottom, 1);
      btn_down = 1'b0; run(2);

      // auto sweep from the bottom
      auto_en = 1'b1; n_up = 0; n_dn = 0;
      run(34);
      chk("auto_up_cnt", n_up, 11);
      chk("auto_top", pos, 11);
      run(6);
      chk("auto_flip_dn", shift_down, 1);
      chk("auto_pos10", pos, 10);
      chk("auto_dn_cnt", n_dn, 1);
      btn_up = 1'b1; cyc();
      chk("auto_preempt", shift_up, 1);
      chk("preempt_pos", pos, 11);
      run(2);
      btn_up = 1'b0; auto_en = 1'b0; run(3);

      // async reset between repeat pulses
      btn_down = 1'b1; run(8); btn_down = 1'b0; run(2);
      btn_up = 1'b1; run(5);
      chk("rep_pulse", shift_up, 1);
      #3 rst = 1'b0;
      #1;
      chk("arst_up", shift_up, 0);
      chk("arst_pos", pos, 9);
      mreset();
      run(3);
      rst = 1'b1; n_up = 0;
      run(10);
      chk("no_repress", n_up, 0);
      btn_up = 1'b0; cyc();
      btn_up = 1'b1; cyc();
      chk("repress", shift_up, 1);
      btn_up = 1'b0; run(2);

      // clock enable freeze mid-repeat
      btn_down = 1'b1; run(8); btn_down = 1'b0; run(2);
      btn_up = 1'b1; run(6);
      ena = 1'b0; n_up = 0;
      run(5);
      chk("ena_cnt", n_up, 0);
      chk("ena_pos", pos, 9);
      ena = 1'b1; cyc();
      chk("ena_resume", shift_up, 1);
      chk("ena_pos10", pos, 10);
      btn_up = 1'b0; run(2);

      // random soak against the model
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 7) == 0) btn_up = ~btn_up;
         if ($urandom_range(0, 7) == 0) btn_down = ~btn_down;
         if ($urandom_range(0, 39) == 0) auto_en = ~auto_en;
         ena = ($urandom_range(0, 15) != 0);
         rst = ($urandom_range(0, 299) != 0);
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
